// File: rtl/xs3_pkg.sv
// Shared constants, state encoding and sizing helper for the XS-3 converters.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xs3_pkg;

   localparam logic [3:0] XS3_OFFSET = 4'd3;
   localparam logic [3:0] XS3_MIN    = 4'b0011;
   localparam logic [3:0] XS3_MAX    = 4'b1100;

   // Plain vector encoding so the states also read cleanly in legacy tools.
   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t CONV = 2'd1;
   localparam state_t DONE = 2'd2;

   // Smallest b with 2**b >= 10**n: the bits needed to hold any n-digit
   // decimal value.  10**9 < 2**30, so 40 trial widths are plenty.
   function automatic int dec_bits(input int n);
      longint p;
      int     b;
      p = 1;
      b = 0;
      for (int i = 0; i < n; i++) p = p * 10;
      for (int k = 0; k < 40; k++) begin
         if ((longint'(1) << k) < p) b = k + 1;
      end
      return b;
   endfunction

endpackage

// File: rtl/xs3_digit_dec.sv
// Decodes one Excess-3 nibble into its decimal value and an invalid flag.
// Latency: combinational.
// Backpressure: none.
// Ports: nib_i = XS-3 nibble; val_o = nib_i - 3 (mod 16); inv_o = nibble outside 0011..1100.
module xs3_digit_dec
   import xs3_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [3:0] val_o,
   output logic       inv_o
);

   // The subtraction wraps for invalid codes; the caller discards the
   // resulting value through the err flag, so no saturation is needed.
   assign val_o = nib_i - XS3_OFFSET;
   assign inv_o = (nib_i < XS3_MIN) || (nib_i > XS3_MAX);

endmodule

// File: rtl/xs3_bin_conv.sv
// Multi-digit Excess-3 to binary converter, one digit per clock, MSD first.
// Latency: out_valid rises DIGITS edges after the accepting edge; one word per DIGITS+2 cycles.
// Backpressure: result/err held in DONE until out_ready; in_ready low from accept until IDLE.
// Ports: in_valid/in_ready/in_xs3 = input word handshake; out_valid/out_ready/result/err =
//        result handshake; err_pos (only with XS3_ERR_POS_EN) = index of the most-significant
//        invalid digit, 0 = LSD.
module xs3_bin_conv
   import xs3_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int OUT_W  = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   in_xs3,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_W-1:0]      result,
`ifdef XS3_ERR_POS_EN
   output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] err_pos,
`endif
   output logic                  err
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   if (DIGITS < 1 || DIGITS > 9) begin : g_bad_digits
      $error("xs3_bin_conv: DIGITS must be 1..9");
   end
   if (OUT_W < dec_bits(DIGITS)) begin : g_bad_width
      $error("xs3_bin_conv: OUT_W too narrow for DIGITS decimal digits");
   end

   state_t              state_q, state_d;
   logic [4*DIGITS-1:0] sr_q, sr_d;
   logic [OUT_W-1:0]    acc_q, acc_d;
   logic                err_q, err_d;
   logic [IW-1:0]       cnt_q, cnt_d;

   logic [3:0]          dig_val;
   logic                dig_inv;

   // The shift register always presents the next digit to process at its top.
   xs3_digit_dec u_dec (
      .nib_i (sr_q[4*DIGITS-1 -: 4]),
      .val_o (dig_val),
      .inv_o (dig_inv)
   );

`ifdef XS3_ERR_POS_EN
   logic [IW-1:0] pos_q, pos_d;
`endif

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      acc_d   = acc_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
`ifdef XS3_ERR_POS_EN
      pos_d   = pos_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sr_d    = in_xs3;
               acc_d   = '0;
               err_d   = 1'b0;
               cnt_d   = '0;
`ifdef XS3_ERR_POS_EN
               pos_d   = '0;
`endif
               state_d = CONV;
            end
         end
         CONV: begin
            // acc*10 as two shifts; OUT_W is sized so valid input never truncates.
            acc_d = (acc_q << 3) + (acc_q << 1) + OUT_W'(dig_val);
            if (dig_inv) begin
               err_d = 1'b1;
`ifdef XS3_ERR_POS_EN
               // Digits arrive MSD first, so the first invalid one is the most significant.
               if (!err_q) pos_d = IW'(DIGITS - 1) - cnt_q;
`endif
            end
            sr_d  = sr_q << 4;
            cnt_d = cnt_q + IW'(1);
            if (cnt_q == IW'(DIGITS - 1)) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sr_q    <= '0;
         acc_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         acc_q   <= acc_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef XS3_ERR_POS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pos_q <= '0;
      else        pos_q <= pos_d;
   end
   assign err_pos = (out_valid && err_q) ? pos_q : '0;
`endif

   // Outputs are masked outside DONE so a partial accumulator is never visible.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = (out_valid && !err_q) ? acc_q : '0;
   assign err       = out_valid && err_q;

endmodule

// File: tb/tb_xs3_bin_conv.sv
module tb_xs3_bin_conv;

   logic        clk = 1'b0;
   logic        rst_n;
   int          cyc = 0;

   // DUT A: DIGITS=4, OUT_W=14
   logic        in_valid, in_ready, out_valid, out_ready, err;
   logic [15:0] in_xs3;
   logic [13:0] result;
   // DUT B: DIGITS=1, OUT_W=4
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err;
   logic [3:0]  b_in_xs3, b_result;
`ifdef XS3_ERR_POS_EN
   logic [1:0]  err_pos;
   logic [0:0]  b_err_pos;
`endif

   xs3_bin_conv #(.DIGITS(4), .OUT_W(14)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_xs3(in_xs3),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
`ifdef XS3_ERR_POS_EN
      .err_pos(err_pos),
`endif
      .err(err));

   xs3_bin_conv #(.DIGITS(1), .OUT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_xs3(b_in_xs3),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .result(b_result),
`ifdef XS3_ERR_POS_EN
      .err_pos(b_err_pos),
`endif
      .err(b_err));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int res;
      bit err;
      int pos;
      int acc_cyc;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   mode     = 0;   // out_ready of DUT A: 0 high, 1 random, 2 low

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference: value = sum (nibble_i - 3) * 10**i over digits; any nibble outside
   // 3..12 is an error, reported at the highest such digit index, with result 0.
   function automatic exp_t model(input logic [15:0] w, input int ndig, input int acc_cyc);
      exp_t e;
      int   scale;
      int   nib;
      e.res = 0; e.err = 0; e.pos = 0; e.acc_cyc = acc_cyc;
      scale = 1;
      for (int i = 0; i < ndig; i++) begin
         nib = int'((w >> (4 * i)) & 16'hF);
         if (nib < 3 || nib > 12) begin
            e.err = 1;
            e.pos = i;
         end else begin
            e.res = e.res + (nib - 3) * scale;
         end
         scale = scale * 10;
      end
      if (e.err) e.res = 0;
      return e;
   endfunction

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         out_ready = (mode == 0) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      end
   end

   // Monitor for DUT A: latency on out_valid rise, hold-stability under backpressure,
   // in_ready behaviour, and pop/compare on handshake.
   initial begin
      bit prev_vld, prev_hold, prev_hs;
      logic [13:0] h_res;
      logic        h_err;
      exp_t        e;
      prev_vld = 0; prev_hold = 0; prev_hs = 0; h_res = '0; h_err = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_vld = 0; prev_hold = 0; prev_hs = 0;
         end else begin
            if (prev_hs) chk("a_in_ready_after_hs", in_ready, 1);
            if (prev_hold) begin
               chk("a_hold_valid", out_valid, 1);
               chk("a_hold_result", result, h_res);
               chk("a_hold_err", err, h_err);
            end
            if (out_valid) chk("a_in_ready_busy", in_ready, 0);
            if (out_valid && !prev_vld) begin
               if (qa.size() == 0) chk("a_unexpected_output", 1, 0);
               else chk("a_latency", cyc - qa[0].acc_cyc, 4);
            end
            if (out_valid && out_ready && qa.size() != 0) begin
               e = qa.pop_front();
               chk("a_result", result, e.res);
               chk("a_err", err, e.err);
`ifdef XS3_ERR_POS_EN
               chk("a_err_pos", err_pos, e.pos);
`endif
            end
            prev_hs   = out_valid && out_ready;
            prev_hold = out_valid && !out_ready;
            prev_vld  = out_valid;
            h_res = result; h_err = err;
         end
      end
   end

   // Monitor for DUT B (single digit, out_ready tied high).
   initial begin
      bit   prev_vld;
      exp_t e;
      prev_vld = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) prev_vld = 0;
         else begin
            if (b_out_valid && !prev_vld) begin
               if (qb.size() == 0) chk("b_unexpected_output", 1, 0);
               else chk("b_latency", cyc - qb[0].acc_cyc, 1);
            end
            if (b_out_valid && b_out_ready && qb.size() != 0) begin
               e = qb.pop_front();
               chk("b_result", b_result, e.res);
               chk("b_err", b_err, e.err);
`ifdef XS3_ERR_POS_EN
               chk("b_err_pos", b_err_pos, e.pos);
`endif
            end
            prev_vld = b_out_valid;
         end
      end
   end

   // Drivers: entered and left at #1 after a rising edge.
   task automatic send_a(input logic [15:0] w);
      int t;
      t = 0;
      in_valid = 1'b1; in_xs3 = w;
      @(negedge clk);
      while (!in_ready && t < 100) begin @(negedge clk); t++; end
      if (!in_ready) begin
         chk("a_accept_timeout", 0, 1);
      end else begin
         qa.push_back(model(w, 4, cyc + 1));
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_xs3 = 16'($urandom);
   endtask

   task automatic send_b(input logic [3:0] w);
      int t;
      t = 0;
      b_in_valid = 1'b1; b_in_xs3 = w;
      @(negedge clk);
      while (!b_in_ready && t < 100) begin @(negedge clk); t++; end
      if (!b_in_ready) chk("b_accept_timeout", 0, 1);
      else qb.push_back(model({12'h000, w}, 1, cyc + 1));
      @(posedge clk); #1;
      b_in_valid = 1'b0; b_in_xs3 = 4'($urandom);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((qa.size() != 0 || qb.size() != 0) && t < 500) begin @(posedge clk); t++; end
      chk("drain", qa.size() + qb.size(), 0);
      @(posedge clk); #1;
   endtask

   function automatic logic [15:0] rand_word();
      logic [15:0] w;
      for (int i = 0; i < 4; i++) begin
         if ($urandom_range(0, 7) == 0) w[4*i +: 4] = 4'($urandom);
         else w[4*i +: 4] = 4'(3 + $urandom_range(0, 9));
      end
      return w;
   endfunction

   initial begin
      int t;
      rst_n = 1'b0;
      in_valid = 1'b0; in_xs3 = '0;
      b_in_valid = 1'b0; b_in_xs3 = '0; b_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_err", err, 0);
      chk("rst_b_in_ready", b_in_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed words through the scoreboard
      mode = 0;
      send_a(16'h4567); drain();
      send_a(16'hCCCC); send_a(16'h3333); drain();
      send_a(16'h45F7); send_a(16'h0333); drain();

      // Backpressure: hold out_ready low, wiggle in_valid with a new word
      mode = 2;
      send_a(16'h5678);
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 50) begin @(negedge clk); t++; end
      chk("bp_out_valid_seen", out_valid, 1);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         in_valid = 1'(k & 1); in_xs3 = 16'h4444;
         @(negedge clk);
         chk("bp_in_ready_low", in_ready, 0);
         chk("bp_out_valid_hold", out_valid, 1);
         if (k == 4) mode = 0;
      end
      @(posedge clk); #1;
      send_a(16'h4444); drain();

      // Reset during the second CONV cycle
      send_a(16'h4567);
      @(posedge clk); #1;
      rst_n = 1'b0;
      qa.delete();
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_result", result, 0);
      chk("abort_in_ready", in_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_a(16'h3C3C); drain();

      // Randomized traffic with random backpressure
      mode = 1;
      for (int n = 0; n < 40; n++) send_a(rand_word());
      drain();
      mode = 0;

      // Single-digit instance: every nibble
      for (int n = 0; n < 16; n++) send_b(4'(n));
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d passed", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
